// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scan controller for a 4x4 keypad matrix. Drives the active-low row lines one
// at a time, synchronises the active-low column returns, debounces over whole
// scan frames and hands one hex key code per press to the consumer.
//
// Parameters
//   SCAN_DIV        cycles each row is driven (dwell), min 4
//   DEBOUNCE_FRAMES consecutive identical frames to confirm press/release, min 1
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   col[3:0]   in   raw column returns, active-low, asynchronous to clk
//   row[3:0]   out  row drive, active-low one-cold
//   key[3:0]   out  confirmed key code, stable while key_valid=1
//   key_valid  out  new key available, held until acknowledged
//   key_ack    in   consumer acknowledge
//   key_held   out  a debounced key is currently pressed
//   overrun    out  one-cycle pulse: press confirmed while key_valid was 1
//
// Handshake: key_valid/key rise together when a press is confirmed and hold
// until a cycle with key_ack=1 while key_valid=1; that edge clears key_valid
// and leaves key unchanged. key_ack while key_valid=0 has no effect. When an
// ack and a confirm land on the same edge, the ack is consumed first and the
// new key is loaded with key_valid staying high (no overrun).
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_e;

    // Team keypad code map, indexed by {row, col}.
    function automatic logic [3:0] code_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // ---------------------------------------------------------------- sync
    logic [3:0] col_meta_q;
    logic [3:0] col_s_q;

    // Reset to "no column pulled low" so nothing looks pressed after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
        end else begin
            col_meta_q <= col;
            col_s_q    <= col_meta_q;
        end
    end

    // ---------------------------------------------------------------- scan
    logic [DW-1:0] dwell_q;
    logic [1:0]    row_idx_q;
    logic          found_q;     // a hit already recorded earlier in this frame
    logic [3:0]    code_q;      // code of that earliest hit

    logic       sample_en;
    logic       frame_end;
    logic       row_hit;
    logic [1:0] low_col;
    logic       frame_found;
    logic [3:0] frame_code;

    always_comb begin
        sample_en = (dwell_q == DWELL_LAST);
        frame_end = sample_en && (row_idx_q == 2'd3);
        row_hit   = (col_s_q != 4'hF);
        // Descending loop leaves the lowest low column index.
        low_col   = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_s_q[c]) begin
                low_col = 2'(c);
            end
        end
        // An earlier row always wins over the row being sampled now.
        frame_found = found_q || row_hit;
        frame_code  = found_q ? code_q : code_map(row_idx_q, low_col);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q   <= '0;
            row_idx_q <= 2'd0;
            found_q   <= 1'b0;
            code_q    <= 4'h0;
        end else if (sample_en) begin
            dwell_q   <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            // Accumulator empties at frame end so the next frame starts fresh.
            found_q   <= frame_found && !frame_end;
            code_q    <= frame_code;
        end else begin
            dwell_q   <= dwell_q + DWELL_ONE;
        end
    end

    assign row = ~(4'b0001 << row_idx_q);

    // ---------------------------------------------------------------- fsm
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    cand_q;
    logic [3:0]    key_q;
    logic          key_valid_q;
    logic          key_held_q;
    logic          overrun_q;

    logic ack_take;
    logic do_confirm;

    always_comb begin
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        ack_take   = key_ack && key_valid_q;
        // Confirm on the frame that completes the run of identical presses.
        do_confirm = frame_end && frame_found &&
                     (((state_q == IDLE) && (DEBOUNCE_FRAMES == 1)) ||
                      ((state_q == DB_PRESS) && (frame_code == cand_q) &&
                       (cnt_q == CNT_LAST)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (ack_take) begin
                key_valid_q <= 1'b0;
            end
            if (frame_end) begin
                case (state_q)
                    IDLE: begin
                        if (frame_found) begin
                            cand_q  <= frame_code;
                            cnt_q   <= CNT_ONE;
                            state_q <= DB_PRESS;
                        end
                    end
                    DB_PRESS: begin
                        if (!frame_found) begin
                            state_q <= IDLE;
                        end else if (frame_code == cand_q) begin
                            cnt_q <= cnt_inc;
                        end else begin
                            cand_q <= frame_code;
                            cnt_q  <= CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        // Any press, even a different key, keeps us here.
                        if (!frame_found) begin
                            if (DEBOUNCE_FRAMES == 1) begin
                                state_q    <= IDLE;
                                key_held_q <= 1'b0;
                            end else begin
                                state_q <= DB_RELEASE;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    DB_RELEASE: begin
                        if (frame_found) begin
                            state_q <= PRESSED;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q    <= IDLE;
                            key_held_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                // Placed after the case so it overrides the IDLE/DB_PRESS moves
                // and, when the ack is taken on this edge, the key_valid clear.
                if (do_confirm) begin
                    state_q    <= PRESSED;
                    key_held_q <= 1'b1;
                    if (!key_valid_q || ack_take) begin
                        key_q       <= frame_code;
                        key_valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2 (16-cycle frame).
// A keypad model pulls a column low when a pressed key sits on the driven row.
// The reference model works per frame: it reduces the pressed-key set to the
// frame's result and confirms/releases from the history of recent results.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SD    = 4;
    localparam int DF    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;

    logic [15:0] pressed;     // bit r*4+c set = key (r,c) held down
    logic [3:0]  code_tab [16];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [3:0] m_key;
    bit         m_valid;
    bit         m_held;
    bit         m_overrun;
    int         hist[$];

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    // ------------------------------------------------------------ clock
    always #5 clk = ~clk;

    // ------------------------------------------------------------ keypad
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && pressed[r*4+c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------ model
    function automatic int frame_result(input logic [15:0] mask);
        int res;
        res = -1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (res < 0 && mask[r*4+c]) begin
                    res = int'(code_tab[r*4+c]);
                end
            end
        end
        return res;
    endfunction

    task automatic model_reset();
        m_key     = 4'h0;
        m_valid   = 1'b0;
        m_held    = 1'b0;
        m_overrun = 1'b0;
        hist.delete();
    endtask

    // One full frame with a fixed pressed set; optional ack on the first cycle
    // or on the frame-end edge. Row and outputs are compared every cycle.
    task automatic run_frame(input logic [15:0] mask, input bit ack_early, input bit ack_late);
        logic [3:0] er;
        int         res;
        bit         same;
        pressed = mask;
        for (int k = 1; k <= FRAME; k++) begin
            key_ack = (k == 1 && ack_early) || (k == FRAME && ack_late);
            @(posedge clk);
            #1;
            key_ack = 1'b0;
            if (k == 1) begin
                m_overrun = 1'b0;
                if (ack_early && m_valid) m_valid = 1'b0;
            end
            if (k == FRAME) begin
                res = frame_result(mask);
                if (ack_late && m_valid) m_valid = 1'b0;
                hist.push_back(res);
                if (hist.size() > DF) void'(hist.pop_front());
                same = (hist.size() == DF);
                foreach (hist[i]) if (hist[i] != res) same = 1'b0;
                if (same && res >= 0 && !m_held) begin
                    m_held = 1'b1;
                    if (m_valid) m_overrun = 1'b1;
                    else begin
                        m_key   = res[3:0];
                        m_valid = 1'b1;
                    end
                end else if (same && res < 0 && m_held) begin
                    m_held = 1'b0;
                end
            end
            er = 4'hF;
            er[(k / SD) % 4] = 1'b0;
            tests_run++;
            if (row !== er) begin
                tests_failed++;
                $display("FAIL row_seq k=%0d actual=%b expected=%b", k, row, er);
            end
            tests_run++;
            if ({key, key_valid, key_held, overrun} !== {m_key, m_valid, m_held, m_overrun}) begin
                tests_failed++;
                $display("FAIL outputs k=%0d actual key=%h v=%b h=%b o=%b expected key=%h v=%b h=%b o=%b",
                         k, key, key_valid, key_held, overrun, m_key, m_valid, m_held, m_overrun);
            end
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst     = 1'b1;
        key_ack = 1'b0;
        pressed = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({row, key, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_values actual row=%b key=%h v=%b h=%b o=%b expected row=1110 key=0 v=0 h=0 o=0",
                     row, key, key_valid, key_held, overrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_scan();
        repeat (2) run_frame(16'h0, 1'b0, 1'b0);
        tests_run++;
        if ({key_valid, key_held} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_scan actual v=%b h=%b expected v=0 h=0", key_valid, key_held);
        end
    endtask

    task automatic test_press_hold();
        logic [15:0] m;
        m = 16'h1 << 6;                      // R1C2
        run_frame(m, 1'b0, 1'b0);
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL press_early actual v=%b expected v=0", key_valid);
        end
        run_frame(m, 1'b0, 1'b0);
        tests_run++;
        if ({key, key_valid, key_held} !== {4'h6, 2'b11}) begin
            tests_failed++;
            $display("FAIL press_6 actual key=%h v=%b h=%b expected key=6 v=1 h=1", key, key_valid, key_held);
        end
        run_frame(m, 1'b1, 1'b0);
        tests_run++;
        if ({key, key_valid} !== {4'h6, 1'b0}) begin
            tests_failed++;
            $display("FAIL ack_6 actual key=%h v=%b expected key=6 v=0", key, key_valid);
        end
        run_frame(16'h0, 1'b0, 1'b0);
        tests_run++;
        if (key_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_early actual h=%b expected h=1", key_held);
        end
        run_frame(16'h0, 1'b0, 1'b0);
        tests_run++;
        if (key_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_6 actual h=%b expected h=0", key_held);
        end
    endtask

    task automatic test_bounce();
        run_frame(16'h1 << 9, 1'b0, 1'b0);   // R2C1 for one frame only
        repeat (3) run_frame(16'h0, 1'b0, 1'b0);
        tests_run++;
        if ({key_valid, key_held} !== 2'b00) begin
            tests_failed++;
            $display("FAIL bounce actual v=%b h=%b expected v=0 h=0", key_valid, key_held);
        end
    endtask

    task automatic test_multi_swap();
        logic [15:0] m;
        m = (16'h1 << 3) | (16'h1 << 8);     // R0C3 + R2C0
        repeat (2) run_frame(m, 1'b0, 1'b0);
        tests_run++;
        if ({key, key_valid} !== {4'hA, 1'b1}) begin
            tests_failed++;
            $display("FAIL multi_A actual key=%h v=%b expected key=a v=1", key, key_valid);
        end
        run_frame(16'h1 << 13, 1'b1, 1'b0);  // swap to R3C1, ack old key
        repeat (2) run_frame(16'h1 << 13, 1'b0, 1'b0);
        tests_run++;
        if ({key, key_valid, key_held} !== {4'hA, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL swap_ignored actual key=%h v=%b h=%b expected key=a v=0 h=1", key, key_valid, key_held);
        end
        repeat (2) run_frame(16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        repeat (2) run_frame(16'h1 << 5, 1'b0, 1'b0);   // 5
        repeat (2) run_frame(16'h0, 1'b0, 1'b0);
        run_frame(16'h1 << 10, 1'b0, 1'b0);             // 9
        run_frame(16'h1 << 10, 1'b0, 1'b0);
        tests_run++;
        if ({overrun, key, key_valid} !== {1'b1, 4'h5, 1'b1}) begin
            tests_failed++;
            $display("FAIL overrun actual o=%b key=%h v=%b expected o=1 key=5 v=1", overrun, key, key_valid);
        end
        run_frame(16'h1 << 10, 1'b0, 1'b0);
        tests_run++;
        if ({overrun, key} !== {1'b0, 4'h5}) begin
            tests_failed++;
            $display("FAIL overrun_after actual o=%b key=%h expected o=0 key=5", overrun, key);
        end
        run_frame(16'h0, 1'b1, 1'b0);
        run_frame(16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_ack_same_edge();
        repeat (2) run_frame(16'h1 << 2, 1'b0, 1'b0);   // 3, left pending
        repeat (2) run_frame(16'h0, 1'b0, 1'b0);
        run_frame(16'h1 << 8, 1'b0, 1'b0);              // 7
        run_frame(16'h1 << 8, 1'b0, 1'b1);              // ack on confirming edge
        tests_run++;
        if ({key, key_valid, overrun} !== {4'h7, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL ack_confirm actual key=%h v=%b o=%b expected key=7 v=1 o=0", key, key_valid, overrun);
        end
        run_frame(16'h0, 1'b1, 1'b0);
        run_frame(16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] m;
        m = 16'h1 << 10;                     // R2C2
        repeat (3) run_frame(m, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({row, key, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_mid actual row=%b key=%h v=%b h=%b o=%b expected row=1110 key=0 v=0 h=0 o=0",
                     row, key, key_valid, key_held, overrun);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run_frame(m, 1'b0, 1'b0);
        tests_run++;
        if ({key, key_valid} !== {4'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_early actual key=%h v=%b expected key=0 v=0", key, key_valid);
        end
        run_frame(m, 1'b0, 1'b0);
        tests_run++;
        if ({key, key_valid} !== {4'h9, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_mid_9 actual key=%h v=%b expected key=9 v=1", key, key_valid);
        end
        run_frame(16'h0, 1'b1, 1'b0);
        run_frame(16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] m;
        m = 16'h0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    m = 16'h0;
                    2:       m = 16'h1 << $urandom_range(0, 15);
                    default: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                endcase
            end
            run_frame(m, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end
        repeat (3) run_frame(16'h0, 1'b1, 1'b0);
    endtask

    // ------------------------------------------------------------ main
    initial begin
        code_tab = '{4'h1, 4'h2, 4'h3, 4'hA,
                     4'h4, 4'h5, 4'h6, 4'hB,
                     4'h7, 4'h8, 4'h9, 4'hC,
                     4'hE, 4'h0, 4'hF, 4'hD};
        model_reset();
        test_reset();
        test_idle_scan();
        test_press_hold();
        test_bounce();
        test_multi_swap();
        test_overrun();
        test_ack_same_edge();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Sequential scan controller for the 4x4 keypad matrix. It drives the active-low row lines one at a time and synchronises the active-low column returns. It debounces presses over whole scan frames and delivers one hex key code per press through a valid/ack handshake. It sits between the physical keypad pins and the downstream consumer, and uses the team's standard keypad code map.

## Interface
- SCAN_DIV, 1000: clock cycles each row is driven (dwell); min 4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames needed to confirm a press or a release; min 1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- col  in  4  raw column returns, active-low, asynchronous to clk.
- row  out  4  row drive, active-low one-cold.
- key  out  4  confirmed key code; stable while key_valid=1.
- key_valid  out  1  new key available; held until acknowledged.
- key_ack  in  1  consumer acknowledge.
- key_held  out  1  a debounced key is currently pressed.
- overrun  out  1  one-cycle pulse: a press was confirmed while key_valid was still 1.

## Operation
- Reset values:
  - row=4'b1110.
  - key=4'h0, key_valid=0, key_held=0, overrun=0.
  - FSM in IDLE; row index 0; dwell counter 0; frame accumulator empty.
- col passes through a 2-flop synchroniser; only the synchronised value col_s is used.
- Row sequencing:
  - Row index r counts 0,1,2,3,0,… and row=~(4'b0001<<r).
  - Dwell counter runs 0..SCAN_DIV-1; col_s is sampled on the cycle the count equals SCAN_DIV-1.
  - r advances on that same edge.
  - One frame = 4*SCAN_DIV cycles, ending with the row-3 sample.
- Frame result: the first row in order 0..3 with any col_s bit low, and within that row the lowest-index low column. Otherwise "none".
- Code map (row,col→code):
  - R0: 1, 2, 3, A.
  - R1: 4, 5, 6, B.
  - R2: 7, 8, 9, C.
  - R3: E, 0, F, D.
- FSM is evaluated only at frame end; cnt is the consecutive-frame counter, cand the candidate code.
  - IDLE:
    - press with code c → cand=c, cnt=1.
    - If DEBOUNCE_FRAMES=1, confirm immediately; else go to DB_PRESS.
  - DB_PRESS:
    - same code → cnt+1; on reaching DEBOUNCE_FRAMES, confirm.
    - different code → cand=new code, cnt=1.
    - none → IDLE.
  - Confirm: go to PRESSED, key_held=1.
    - If key_valid=0: key=cand, key_valid=1.
    - Else: key is unchanged and overrun pulses.
  - PRESSED:
    - none → DB_RELEASE, cnt=1; if DEBOUNCE_FRAMES=1, go straight to IDLE.
    - any press, including a different code → stay. No roll-over; the second key is ignored.
  - DB_RELEASE:
    - none → cnt+1; on reaching DEBOUNCE_FRAMES → IDLE, key_held=0.
    - press → PRESSED.
- Handshake:
  - key_ack=1 while key_valid=1 clears key_valid on that edge; key keeps its value.
  - key_ack with key_valid=0 is ignored.
  - If an ack and a confirm occur on the same edge, the ack wins first, then the confirm loads the new key: key_valid stays 1, key is updated, no overrun.
- Counters saturate, never wrap. cnt width is clog2(DEBOUNCE_FRAMES+1).

## Timing
- Synchroniser latency: 2 cycles. Sampling at dwell end gives SCAN_DIV-3 cycles of settling after a row change.
- Press-to-key_valid latency: key_valid and key_held rise on the edge of the DEBOUNCE_FRAMES-th consecutive matching frame-end sample, visible the following cycle. This is at most (DEBOUNCE_FRAMES+1)*4*SCAN_DIV+2 cycles from a stable press.
- Release latency: key_held falls on the edge of the DEBOUNCE_FRAMES-th consecutive "none" frame end.
- overrun: high for exactly the one cycle after the confirming edge.
- Reset asserted at any time, including mid-frame or in PRESSED:
  - all outputs return to reset values immediately.
  - no key is reported afterwards until a full new debounce completes.

## Test plan
Bench keypad model: col[c]=0 iff some pressed key (r,c) has row[r]=0. Settings: SCAN_DIV=4, DEBOUNCE_FRAMES=2, so one frame is 16 cycles.
- Reset, no keys pressed:
  - row cycles 1110→1101→1011→0111, 4 cycles each, repeating.
  - key=0, key_valid=0, key_held=0, overrun=0 throughout.
- Press R1C2 and hold:
  - key=4'h6, key_valid=1, key_held=1 at the end of the 2nd full frame.
  - pulse key_ack → key_valid=0 the next cycle.
  - release → key_held=0 after 2 empty frames.
- Bounce: press present for 1 frame then absent → key_valid and key_held never assert.
- Simultaneous R0C3 and R2C0 → key=4'hA.
  - While in PRESSED, swap to only R3C1 without releasing → no new key_valid.
- Overrun: confirm 5 with no ack, release, then confirm 9 → overrun one-cycle pulse; key stays 4'h5; key_valid stays 1.
- Reset mid-PRESSED with R2C2 held:
  - all outputs return to reset values.
  - after reset release, key=4'h9 and key_valid=1 only after 2 new full frames.
